// File: rtl/scr1_dbg_chain_ctrl.sv
// DMI/DTMCS scan-chain controller: a single shift register feeds either the
// DTMCS status word or a DMI request, and a two-state FSM tracks the DM handshake.
module scr1_dbg_chain_ctrl #(
  parameter int ABITS    = 7,
  parameter int CH_ID_W  = 2,
  parameter int ID_DTMCS = 1,
  parameter int ID_DMI   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ch_sel_i,
  input  logic [CH_ID_W-1:0] ch_id_i,
  input  logic               ch_capture_i,
  input  logic               ch_shift_i,
  input  logic               ch_update_i,
  input  logic               ch_tdi_i,
  output logic               ch_tdo_o,
  output logic               dmi_req_o,
  output logic               dmi_wr_o,
  output logic [ABITS-1:0]   dmi_addr_o,
  output logic [31:0]        dmi_wdata_o,
  input  logic               dmi_resp_i,
  input  logic [31:0]        dmi_rdata_i
);

  localparam int W = ABITS + 34;
  localparam logic [CH_ID_W-1:0] IdDtmcs = CH_ID_W'(ID_DTMCS);
  localparam logic [CH_ID_W-1:0] IdDmi   = CH_ID_W'(ID_DMI);

  typedef enum logic {IDLE, REQ} state_e;

  state_e           state_q;
  logic [W-1:0]     sr_q, sr_d;
  logic [ABITS-1:0] addr_q;
  logic [31:0]      rdata_q;
  logic [31:0]      wdata_q;
  logic             wr_q;
  logic             sticky_q;

  logic             is_dmi, is_dtmcs;
  logic [1:0]       stat;
  logic [1:0]       sr_op;
  logic [31:0]      sr_data;
  logic [ABITS-1:0] sr_addr;
  logic [31:0]      dtmcs;

  assign is_dmi   = (ch_id_i == IdDmi);
  assign is_dtmcs = (ch_id_i == IdDtmcs);
  assign stat     = (sticky_q || state_q == REQ) ? 2'b11 : 2'b00;
  assign sr_op    = sr_q[1:0];
  assign sr_data  = sr_q[33:2];
  assign sr_addr  = sr_q[W-1:34];
  assign dtmcs    = {17'd0, 3'd1, stat, 6'(ABITS), 4'd1};

  // Update outranks capture, which outranks shift; update never touches SR.
  always_comb begin
    sr_d = sr_q;
    if (ch_sel_i && !ch_update_i) begin
      if (ch_capture_i) begin
        if (is_dmi)        sr_d = {addr_q, rdata_q, stat};
        else if (is_dtmcs) sr_d = {{(W-32){1'b0}}, dtmcs};
        else               sr_d = '0;
      end else if (ch_shift_i) begin
        sr_d = {ch_tdi_i, sr_q[W-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      addr_q   <= '0;
      rdata_q  <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      sr_q <= sr_d;
      if (state_q == REQ && dmi_resp_i) begin
        state_q <= IDLE;
        if (!wr_q) rdata_q <= dmi_rdata_i;
      end
      if (ch_sel_i && ch_capture_i && !ch_update_i && is_dmi && state_q == REQ)
        sticky_q <= 1'b1;
      // A hardreset written later in this block wins over a same-cycle response.
      if (ch_sel_i && ch_update_i) begin
        if (is_dtmcs) begin
          if (sr_q[16] || sr_q[17]) sticky_q <= 1'b0;
          if (sr_q[17])             state_q  <= IDLE;
        end else if (is_dmi) begin
          if (state_q == REQ) begin
            sticky_q <= 1'b1;
          end else if (!sticky_q && (sr_op == 2'd1 || sr_op == 2'd2)) begin
            addr_q  <= sr_addr;
            wdata_q <= sr_data;
            wr_q    <= (sr_op == 2'd2);
            state_q <= REQ;
          end
        end
      end
    end
  end

  assign ch_tdo_o    = ch_sel_i & sr_q[0];
  assign dmi_req_o   = (state_q == REQ);
  assign dmi_wr_o    = wr_q;
  assign dmi_addr_o  = addr_q;
  assign dmi_wdata_o = wdata_q;

endmodule

// File: tb/tb_scr1_dbg_chain_ctrl.sv
// Directed bench for scr1_dbg_chain_ctrl; expected DMI requests and captured
// scan words are queued when stimulus is driven and popped when the DUT produces them.
module tb_scr1_dbg_chain_ctrl;

  localparam int W = 41;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ch_sel_i, ch_capture_i, ch_shift_i, ch_update_i, ch_tdi_i;
  logic [1:0]  ch_id_i;
  logic        ch_tdo_o, dmi_req_o, dmi_wr_o;
  logic [6:0]  dmi_addr_o;
  logic [31:0] dmi_wdata_o;
  logic        dmi_resp_i;
  logic [31:0] dmi_rdata_i;

  int checks = 0;
  int errors = 0;

  logic [39:0]  reqQ[$];
  logic [W-1:0] capQ[$];

  scr1_dbg_chain_ctrl #(.ABITS(7), .CH_ID_W(2), .ID_DTMCS(1), .ID_DMI(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_sel_i(ch_sel_i), .ch_id_i(ch_id_i),
    .ch_capture_i(ch_capture_i), .ch_shift_i(ch_shift_i), .ch_update_i(ch_update_i),
    .ch_tdi_i(ch_tdi_i), .ch_tdo_o(ch_tdo_o),
    .dmi_req_o(dmi_req_o), .dmi_wr_o(dmi_wr_o), .dmi_addr_o(dmi_addr_o),
    .dmi_wdata_o(dmi_wdata_o), .dmi_resp_i(dmi_resp_i), .dmi_rdata_i(dmi_rdata_i)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] %s mismatch", tag);
    end
  endtask

  task automatic applyStimulus(input logic cap, input logic upd, input logic sh,
                               input logic tdi, input logic [1:0] id);
    ch_capture_i = cap;
    ch_update_i  = upd;
    ch_shift_i   = sh;
    ch_tdi_i     = tdi;
    ch_id_i      = id;
    tick();
    ch_capture_i = 1'b0;
    ch_update_i  = 1'b0;
    ch_shift_i   = 1'b0;
    ch_tdi_i     = 1'b0;
  endtask

  function automatic logic [W-1:0] mkSr(input logic [6:0] a, input logic [31:0] d,
                                        input logic [1:0] op);
    return {a, d, op};
  endfunction

  task automatic shiftIn(input logic [W-1:0] v);
    for (int i = 0; i < W; i++) applyStimulus(1'b0, 1'b0, 1'b1, v[i], 2'd2);
  endtask

  task automatic shiftOutCheck(input string tag);
    logic [W-1:0] got;
    logic [W-1:0] exp;
    for (int i = 0; i < W; i++) begin
      got[i] = ch_tdo_o;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'd2);
    end
    if (capQ.size() == 0) begin
      checkOutput({tag, "QueueEmpty"}, 64'd0, 64'd1);
    end else begin
      exp = capQ.pop_front();
      checkOutput(tag, 64'(got), 64'(exp));
    end
  endtask

  task automatic expectReq(input string tag);
    logic [39:0] exp;
    checkOutput({tag, "Req"}, 64'(dmi_req_o), 64'd1);
    if (reqQ.size() == 0) begin
      checkOutput({tag, "QueueEmpty"}, 64'd0, 64'd1);
    end else begin
      exp = reqQ.pop_front();
      checkOutput({tag, "Fields"}, 64'({dmi_wr_o, dmi_addr_o, dmi_wdata_o}), 64'(exp));
    end
  endtask

  task automatic respond(input string tag, input logic [31:0] rdata);
    dmi_rdata_i = rdata;
    dmi_resp_i  = 1'b1;
    tick();
    dmi_resp_i  = 1'b0;
    checkOutput({tag, "Idle"}, 64'(dmi_req_o), 64'd0);
  endtask

  initial begin
    logic [W-1:0] pat;
    rst_n = 1'b0;
    ch_sel_i = 1'b1; ch_id_i = 2'd0;
    ch_capture_i = 1'b0; ch_shift_i = 1'b0; ch_update_i = 1'b0; ch_tdi_i = 1'b0;
    dmi_resp_i = 1'b0; dmi_rdata_i = '0;
    #12;
    checkOutput("rstReq", 64'(dmi_req_o), 64'd0);
    checkOutput("rstTdo", 64'(ch_tdo_o), 64'd0);
    checkOutput("rstOutputs", 64'({dmi_wr_o, dmi_addr_o, dmi_wdata_o}), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Write with a slow DM response.
    shiftIn(mkSr(7'h10, 32'hDEADBEEF, 2'd2));
    reqQ.push_back({1'b1, 7'h10, 32'hDEADBEEF});
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    expectReq("write");
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("writeHold", 64'(dmi_req_o), 64'd1);
    end
    respond("write", 32'h0);

    // Read, then capture the result back out.
    shiftIn(mkSr(7'h11, 32'h0, 2'd1));
    reqQ.push_back({1'b0, 7'h11, 32'h0});
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    expectReq("read");
    respond("read", 32'h12345678);
    capQ.push_back(mkSr(7'h11, 32'h12345678, 2'b00));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    shiftOutCheck("readCapture");

    // Capture while busy makes the busy status sticky.
    shiftIn(mkSr(7'h05, 32'h0, 2'd1));
    reqQ.push_back({1'b0, 7'h05, 32'h0});
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    expectReq("busyRead");
    capQ.push_back(mkSr(7'h05, 32'h12345678, 2'b11));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    shiftOutCheck("busyCapture");
    respond("busyRead", 32'hA5A5A5A5);
    shiftIn(mkSr(7'h06, 32'h0, 2'd1));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    checkOutput("stickyBlocks", 64'(dmi_req_o), 64'd0);
    tick();
    checkOutput("stickyBlocks2", 64'(dmi_req_o), 64'd0);
    capQ.push_back(mkSr(7'h05, 32'hA5A5A5A5, 2'b11));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    shiftOutCheck("stickyCapture");

    // dmireset clears the sticky status.
    pat = '0; pat[16] = 1'b1;
    shiftIn(pat);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    capQ.push_back({9'd0, 32'h00001071});
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    shiftOutCheck("dtmcsIdle");
    shiftIn(mkSr(7'h07, 32'h0, 2'd1));
    reqQ.push_back({1'b0, 7'h07, 32'h0});
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    expectReq("afterDmireset");
    respond("afterDmireset", 32'h0BADF00D);

    // DTMCS while busy, then hardreset aborts the request.
    shiftIn(mkSr(7'h08, 32'h55, 2'd2));
    reqQ.push_back({1'b1, 7'h08, 32'h55});
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    expectReq("hardWrite");
    capQ.push_back({9'd0, 32'h00001C71});
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    shiftOutCheck("dtmcsBusy");
    pat = '0; pat[17] = 1'b1;
    shiftIn(pat);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    checkOutput("hardreset", 64'(dmi_req_o), 64'd0);
    capQ.push_back(mkSr(7'h08, 32'h0BADF00D, 2'b00));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    shiftOutCheck("afterHardreset");

    // Deselected chain ignores every strobe.
    shiftIn(mkSr(7'h09, 32'h0F0F0F0F, 2'd1));
    ch_sel_i = 1'b0;
    #1 checkOutput("deselTdo", 64'(ch_tdo_o), 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 2'd2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 2'd1);
    checkOutput("deselReq", 64'(dmi_req_o), 64'd0);
    checkOutput("deselTdo2", 64'(ch_tdo_o), 64'd0);
    ch_sel_i = 1'b1;
    #1 checkOutput("reselTdo", 64'(ch_tdo_o), 64'd1);
    reqQ.push_back({1'b0, 7'h09, 32'h0F0F0F0F});
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    expectReq("deselKept");
    respond("deselKept", 32'h0);

    // Update and capture together: only the update acts.
    pat = mkSr(7'h0A, 32'h77, 2'd2);
    shiftIn(pat);
    reqQ.push_back({1'b1, 7'h0A, 32'h77});
    capQ.push_back(pat);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'd2);
    expectReq("updCap");
    shiftOutCheck("updCapSr");
    respond("updCap", 32'h0);

    // Other chain IDs capture zero.
    shiftIn(mkSr(7'h7F, 32'hFFFFFFFF, 2'd3));
    capQ.push_back('0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd3);
    shiftOutCheck("otherId");

    // Reset in the middle of a request.
    shiftIn(mkSr(7'h0B, 32'h0, 2'd1));
    reqQ.push_back({1'b0, 7'h0B, 32'h0});
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    expectReq("preReset");
    #2 rst_n = 1'b0;
    #1 checkOutput("midResetReq", 64'(dmi_req_o), 64'd0);
    checkOutput("midResetOut", 64'({dmi_wr_o, dmi_addr_o, dmi_wdata_o}), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    shiftIn(mkSr(7'h0C, 32'h0, 2'd1));
    reqQ.push_back({1'b0, 7'h0C, 32'h0});
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    expectReq("postReset");
    respond("postReset", 32'h3C3C3C3C);

    // A response while idle must not disturb the captured read data.
    dmi_rdata_i = 32'hFFFFFFFF;
    dmi_resp_i  = 1'b1;
    tick();
    dmi_resp_i  = 1'b0;
    capQ.push_back(mkSr(7'h0C, 32'h3C3C3C3C, 2'b00));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    shiftOutCheck("idleResp");

    checkOutput("reqQueueDrained", 64'(reqQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scr1_dbg_chain_ctrl.md
SCR1_DBG_CHAIN_CTRL -- requirements
Module: scr1_dbg_chain_ctrl

Interface
REQ-001 SHALL have parameter ABITS, default 7, DMI address width.
REQ-002 SHALL have parameter CH_ID_W, default 2, chain-identifier width.
REQ-003 SHALL have parameter ID_DTMCS, default 1, chain ID of the DTMCS register.
REQ-004 SHALL have parameter ID_DMI, default 2, chain ID of the DMI access register.
REQ-005 SHALL have port clk, input, 1, system clock; the block uses this single clock.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port ch_sel_i, input, 1, DMI chain selected (SysCLK domain, level).
REQ-008 SHALL have port ch_id_i, input, CH_ID_W, selected chain identifier (level).
REQ-009 SHALL have ports ch_capture_i, ch_shift_i and ch_update_i, each input, 1, single-cycle strobes.
REQ-010 SHALL have port ch_tdi_i, input, 1, serial data in, valid with ch_shift_i.
REQ-011 SHALL have port ch_tdo_o, output, 1, serial data out.
REQ-012 SHALL have port dmi_req_o, output, 1, DM request.
REQ-013 SHALL have port dmi_wr_o, output, 1, request is a write.
REQ-014 SHALL have port dmi_addr_o, output, ABITS, request address.
REQ-015 SHALL have port dmi_wdata_o, output, 32, write data.
REQ-016 SHALL have port dmi_resp_i, input, 1, DM response strobe.
REQ-017 SHALL have port dmi_rdata_i, input, 32, read data, valid with dmi_resp_i.

Function
REQ-018 SHALL hold one shift register SR of width W=ABITS+34, laid out as {addr[ABITS-1:0], data[31:0], op[1:0]}, with op in bits [1:0].
REQ-019 SHALL ignore all strobes while ch_sel_i=0, and SHALL drive ch_tdo_o=0 while ch_sel_i=0.
REQ-020 SHALL use the following priority when strobes coincide: update, then capture, then shift; only one strobe SHALL take effect per cycle.
REQ-021 Shift (any chain ID) SHALL set SR <= {ch_tdi_i, SR[W-1:1]}; ch_tdo_o SHALL equal SR[0] combinationally.
REQ-022 Capture with ch_id_i=ID_DMI SHALL load SR <= {last_addr, last_rdata, stat}, where stat = 2'b11 if sticky_busy=1 or FSM=REQ, else 2'b00.
REQ-023 Capture with ch_id_i=ID_DMI while FSM=REQ SHALL also set sticky_busy.
REQ-024 Capture with ch_id_i=ID_DTMCS SHALL load SR[31:0] <= DTMCS and clear the remaining SR bits.
REQ-025 DTMCS SHALL be composed as: [3:0]=4'd1, [9:4]=ABITS, [11:10]=stat, [14:12]=3'd1, all other bits 0.
REQ-026 Capture with any other chain ID SHALL load SR <= 0.
REQ-027 Update with ch_id_i=ID_DTMCS SHALL clear sticky_busy when SR[16]=1 (dmireset).
REQ-028 Update with ch_id_i=ID_DTMCS SHALL, when SR[17]=1 (dmihardreset), clear sticky_busy, force the FSM to IDLE and deassert dmi_req_o on the next clock edge.
REQ-029 Update with ch_id_i=ID_DMI while FSM=REQ SHALL set sticky_busy and SHALL NOT issue a request.
REQ-030 Update with ch_id_i=ID_DMI while FSM=IDLE and sticky_busy=1 SHALL be ignored.
REQ-031 Update with ch_id_i=ID_DMI while FSM=IDLE and sticky_busy=0 SHALL act on op as follows: 0 nop; 1 read; 2 write; 3 ignored.
REQ-032 A read or write started per REQ-031 SHALL latch addr and data into last_addr and dmi_wdata_o, set dmi_wr_o=(op==2), and enter REQ on the next cycle.
REQ-033 The FSM SHALL have exactly two states, IDLE and REQ; dmi_req_o SHALL equal 1 if and only if FSM=REQ.
REQ-034 In REQ, the FSM SHALL remain until dmi_resp_i=1 and SHALL return to IDLE on the following edge.
REQ-035 If dmi_resp_i=1 for a read, the block SHALL latch last_rdata <= dmi_rdata_i.
REQ-036 If dmi_resp_i=1 for a write, the block SHALL leave last_rdata unchanged.
REQ-037 The block SHALL ignore dmi_resp_i in IDLE.
REQ-038 dmi_addr_o, dmi_wr_o and dmi_wdata_o SHALL be stable for the whole time FSM=REQ.
REQ-039 Minimum request latency SHALL be 1 cycle from update to dmi_req_o=1; a response in the first REQ cycle SHALL give IDLE one cycle later.

Reset
REQ-040 On rst_n=0, the block SHALL asynchronously clear SR, last_addr, last_rdata, sticky_busy, dmi_wr_o, dmi_addr_o and dmi_wdata_o, and set FSM=IDLE; hence dmi_req_o=0 and ch_tdo_o=0.
REQ-041 Reset asserted mid-request SHALL abort the request with no response required; the first update after release SHALL be accepted.

Verification
REQ-042 Scenario: shift in op=2, data=0xDEADBEEF, addr=0x10 and update on ID_DMI -> dmi_req_o=1 next cycle, dmi_wr_o=1, addr 0x10, wdata 0xDEADBEEF; hold dmi_resp_i low 5 cycles -> req stays 1; resp -> IDLE.
REQ-043 Scenario: read at addr 0x11 with DM returning rdata 0x12345678, then capture on ID_DMI and shift W bits -> ch_tdo_o stream LSB-first is op=00, data 0x12345678, addr 0x11.
REQ-044 Scenario: capture on ID_DMI during REQ -> stat=11 and sticky_busy=1; later update op=1 -> no request.
REQ-045 Scenario: after REQ-044, update on ID_DTMCS with bit16=1 -> sticky_busy cleared; next read is accepted.
REQ-046 Scenario: DTMCS capture with ABITS=7 -> shifted-out 32 bits equal 0x00001071; hardreset during REQ -> dmi_req_o=0 next cycle.
REQ-047 Scenario: ch_sel_i=0 with all strobes pulsed -> SR, FSM and outputs unchanged; ch_tdo_o=0; update and capture strobes in the same cycle -> only the update takes effect.
